// File: rtl/dg_pkg.sv
// Shared constants and helpers for the multi-channel gain/AGC block.
// Widths here set the defaults of the top-level parameters.
package dg_pkg;

  localparam int DG_IN_W    = 48;
  localparam int DG_OUT_W   = 16;
  localparam int DG_SHIFT_W = 6;
  localparam int SMAX       = DG_IN_W - DG_OUT_W;
  localparam int LEN_W      = $clog2(DG_IN_W + 1);

  typedef struct packed {
    logic valid;
    logic first;
    logic last;
  } s1_flags_t;

  function automatic logic [LEN_W-1:0] bitlen(
    input logic [DG_IN_W-1:0] v
  );
    logic [LEN_W-1:0] n;
    n = '0;
    for (int i = 0; i < DG_IN_W; i++)
      if (v[i]) n = LEN_W'(i + 1);
    return n;
  endfunction

  function automatic logic [DG_SHIFT_W-1:0] clamp_shift(
    input logic [DG_SHIFT_W:0] v
  );
    if (int'(v) > SMAX) return DG_SHIFT_W'(SMAX);
    return v[DG_SHIFT_W-1:0];
  endfunction

endpackage

// File: rtl/gain_lane.sv
// One lane of window select, round-half-up and saturation.
// Purely combinational; the top level registers the result.
module gain_lane
  import dg_pkg::*;
#(
  parameter int IN_W    = DG_IN_W,
  parameter int OUT_W   = DG_OUT_W,
  parameter int SHIFT_W = DG_SHIFT_W
) (
  input  logic [IN_W-1:0]    din,
  input  logic [SHIFT_W-1:0] shift,
  output logic [OUT_W-1:0]   dout,
  output logic               sat
);

  logic [IN_W-1:0] win;
  logic [IN_W-1:0] rsh;
  logic            rnd;
  logic            hi;
  logic [OUT_W:0]  sum;

  // shift down, add the bit just below the window, clip on overflow
  always_comb begin
    win  = din >> shift;
    rsh  = din >> (shift - SHIFT_W'(1));
    rnd  = (shift != '0) & rsh[0];
    hi   = |win[IN_W-1:OUT_W];
    sum  = {1'b0, win[OUT_W-1:0]}
         + {{OUT_W{1'b0}}, rnd};
    sat  = hi | sum[OUT_W];
    dout = sat ? '1 : sum[OUT_W-1:0];
  end

endmodule

// File: rtl/digital_gain_agc.sv
// Multi-channel gain stage with frame peak tracking and AGC.
// Two-cycle data path; shift chosen at frame start.
module digital_gain_agc
  import dg_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int IN_W      = DG_IN_W,
  parameter int OUT_W     = DG_OUT_W,
  parameter int FRAME_LEN = 512,
  parameter int CNT_W     = $clog2(FRAME_LEN),
  parameter int SHIFT_W   = DG_SHIFT_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en_sync_in,
  input  logic [CNT_W-1:0]        cnt_sync_in,
  input  logic [NUM_CH*IN_W-1:0]  data_in,
  input  logic                    mode,
  input  logic [SHIFT_W-1:0]      manual_shift,
  input  logic [SHIFT_W-1:0]      agc_headroom,
  output logic [NUM_CH*OUT_W-1:0] data_out,
  output logic [NUM_CH-1:0]       sat_out,
  output logic                    en_sync_out,
  output logic [CNT_W-1:0]        cnt_sync_out,
  output logic [SHIFT_W-1:0]      cur_shift,
  output logic [IN_W-1:0]         frame_max,
  output logic                    frame_max_valid,
  output logic                    frame_sat
);

  logic               accept;
  logic               start;
  logic               last;
  logic               last_ok;
  logic               in_frame;
  logic [IN_W-1:0]    cur_max;
  logic [IN_W-1:0]    acc;
  logic [IN_W-1:0]    peak_now;
  logic [SHIFT_W-1:0] active_shift;
  logic [SHIFT_W-1:0] pending_shift;
  logic               pending_valid;
  logic [SHIFT_W-1:0] new_shift;
  logic [SHIFT_W-1:0] shift_sel;

  logic [NUM_CH*IN_W-1:0] d1;
  logic [SHIFT_W-1:0]     s1;
  logic                   en1;
  logic [CNT_W-1:0]       cnt1;
  s1_flags_t              f1;

  logic [NUM_CH*OUT_W-1:0] q2;
  logic [NUM_CH-1:0]       sat2;
  logic                    any_sat;
  logic                    sticky;
  logic                    sticky_nxt;

  logic [LEN_W-1:0]   fm_len;
  logic [SHIFT_W:0]   agc_raw;

  // stage 0: frame markers, sample peak, shift choice
  always_comb begin
    accept   = en_sync_in;
    start    = accept && (cnt_sync_in == '0);
    last     = accept
            && (cnt_sync_in == CNT_W'(FRAME_LEN - 1));
    last_ok  = last && (start || in_frame);
    cur_max  = '0;
    for (int k = 0; k < NUM_CH; k++)
      if (data_in[k*IN_W +: IN_W] > cur_max)
        cur_max = data_in[k*IN_W +: IN_W];
    peak_now = (start || cur_max > acc) ? cur_max : acc;
    new_shift = active_shift;
    unique case (1'b1)
      !mode:
        new_shift = clamp_shift({1'b0, manual_shift});
      mode && pending_valid:
        new_shift = pending_shift;
      mode && !pending_valid:
        new_shift = active_shift;
    endcase
    shift_sel = start ? new_shift : active_shift;
  end

  // frame tracking: active shift, running peak, frame membership
  always_ff @(posedge clk) begin
    if (rst) begin
      active_shift <= SHIFT_W'(SMAX);
      acc          <= '0;
      in_frame     <= 1'b0;
    end else begin
      if (start) active_shift <= new_shift;
      if (accept) acc <= peak_now;
      if (last) in_frame <= 1'b0;
      else if (start) in_frame <= 1'b1;
    end
  end

  // publish the completed frame's peak one cycle after its last sample
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_max       <= '0;
      frame_max_valid <= 1'b0;
    end else begin
      frame_max_valid <= last_ok;
      if (last_ok) frame_max <= peak_now;
    end
  end

  // stage 1: register data, shift and frame markers
  always_ff @(posedge clk) begin
    if (rst) begin
      d1   <= '0;
      s1   <= '0;
      en1  <= 1'b0;
      cnt1 <= '0;
      f1   <= '0;
    end else begin
      d1   <= data_in;
      s1   <= shift_sel;
      en1  <= en_sync_in;
      cnt1 <= cnt_sync_in;
      f1   <= '{valid: accept, first: start, last: last_ok};
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
    gain_lane #(
      .IN_W    (IN_W),
      .OUT_W   (OUT_W),
      .SHIFT_W (SHIFT_W)
    ) u_lane (
      .din   (d1[k*IN_W +: IN_W]),
      .shift (s1),
      .dout  (q2[k*OUT_W +: OUT_W]),
      .sat   (sat2[k])
    );
  end

  // saturation collected over accepted samples of the frame
  always_comb begin
    any_sat    = |sat2;
    sticky_nxt = (f1.first ? 1'b0 : sticky) | any_sat;
  end

  // stage 2: output registers and saturation snapshot
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out     <= '0;
      sat_out      <= '0;
      en_sync_out  <= 1'b0;
      cnt_sync_out <= '0;
      cur_shift    <= '0;
      sticky       <= 1'b0;
      frame_sat    <= 1'b0;
    end else begin
      data_out     <= q2;
      sat_out      <= sat2;
      en_sync_out  <= en1;
      cnt_sync_out <= cnt1;
      cur_shift    <= s1;
      if (f1.valid) begin
        sticky <= f1.last ? 1'b0 : sticky_nxt;
        if (f1.last) frame_sat <= sticky_nxt;
      end
    end
  end

  // shift needed to fit the last peak, plus headroom
  always_comb begin
    fm_len  = bitlen(frame_max);
    agc_raw = (SHIFT_W+1)'(agc_headroom);
    if (fm_len > LEN_W'(OUT_W))
      agc_raw = agc_raw
              + (SHIFT_W+1)'(fm_len - LEN_W'(OUT_W));
  end

  // latch the AGC proposal the cycle after a new peak appears
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_shift <= '0;
      pending_valid <= 1'b0;
    end else if (frame_max_valid) begin
      pending_shift <= clamp_shift(agc_raw);
      pending_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_digital_gain_agc.sv
// Scoreboard bench for digital_gain_agc.
// Expected lane outputs come from an arithmetic reference.
module tb_digital_gain_agc;

  logic          clk = 1'b0;
  logic          rst;
  logic          en_sync_in;
  logic [8:0]    cnt_sync_in;
  logic [191:0]  data_in;
  logic          mode;
  logic [5:0]    manual_shift;
  logic [5:0]    agc_headroom;
  logic [63:0]   data_out;
  logic [3:0]    sat_out;
  logic          en_sync_out;
  logic [8:0]    cnt_sync_out;
  logic [5:0]    cur_shift;
  logic [47:0]   frame_max;
  logic          frame_max_valid;
  logic          frame_sat;

  always #5 clk = ~clk;

  digital_gain_agc dut (
    .clk             (clk),
    .rst             (rst),
    .en_sync_in      (en_sync_in),
    .cnt_sync_in     (cnt_sync_in),
    .data_in         (data_in),
    .mode            (mode),
    .manual_shift    (manual_shift),
    .agc_headroom    (agc_headroom),
    .data_out        (data_out),
    .sat_out         (sat_out),
    .en_sync_out     (en_sync_out),
    .cnt_sync_out    (cnt_sync_out),
    .cur_shift       (cur_shift),
    .frame_max       (frame_max),
    .frame_max_valid (frame_max_valid),
    .frame_sat       (frame_sat)
  );

  typedef struct packed {
    logic [63:0] d;
    logic [3:0]  sat;
    logic        en;
    logic [8:0]  cnt;
    logic [5:0]  sh;
  } exp_t;

  exp_t        q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          vcount = 0;
  int          watch_cnt = -1;
  logic [47:0] last_fm = '0;
  logic [63:0] snap_d = '0;
  logic [3:0]  snap_sat = '0;
  logic [5:0]  snap_s = '0;

  function automatic void model(
    input  logic [47:0] x,
    input  int          s,
    output logic [15:0] o,
    output logic        st
  );
    logic [48:0] v;
    v = 49'(x >> s);
    if (s > 0) v = v + 49'((x >> (s - 1)) & 48'd1);
    if (v > 49'hFFFF) begin
      o  = 16'hFFFF;
      st = 1'b1;
    end else begin
      o  = v[15:0];
      st = 1'b0;
    end
  endfunction

  always @(negedge clk) begin : chk
    exp_t e;
    if (!rst && q.size() >= 3) begin
      e = q.pop_front();
      n_cmp++;
      if ({data_out, sat_out, en_sync_out, cnt_sync_out, cur_shift}
          !== {e.d, e.sat, e.en, e.cnt, e.sh}) begin
        n_err++;
        $display("FAIL pipe: got d=%h sat=%b en=%b cnt=%0d sh=%0d, want d=%h sat=%b en=%b cnt=%0d sh=%0d",
                 data_out, sat_out, en_sync_out, cnt_sync_out, cur_shift,
                 e.d, e.sat, e.en, e.cnt, e.sh);
      end
    end
  end

  always @(negedge clk) begin
    if (frame_max_valid) begin
      vcount++;
      last_fm = frame_max;
    end
    if (!rst && en_sync_out && cnt_sync_out == 9'(watch_cnt)) begin
      snap_d   = data_out;
      snap_sat = sat_out;
      snap_s   = cur_shift;
    end
  end

  task automatic drive(input logic e, input int c,
                       input logic [191:0] d, input int s);
    exp_t x;
    logic [15:0] o;
    logic st;
    en_sync_in  = e;
    cnt_sync_in = 9'(c);
    data_in     = d;
    x.en  = e;
    x.cnt = 9'(c);
    x.sh  = 6'(s);
    x.d   = '0;
    x.sat = '0;
    for (int k = 0; k < 4; k++) begin
      model(d[k*48 +: 48], s, o, st);
      x.d[k*16 +: 16] = o;
      x.sat[k] = st;
    end
    q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input int s);
    for (int i = 0; i < n; i++) drive(1'b0, 0, '0, s);
  endtask

  task automatic run_frame(input int c0, input int c1, input int s,
                           input int sp_cnt, input logic [191:0] sp,
                           input logic [47:0] fmask, input int hole,
                           input int chg_cnt, input logic [5:0] chg_val);
    logic [191:0] d;
    logic [63:0]  r;
    for (int c = c0; c <= c1; c++) begin
      if (c == chg_cnt) manual_shift = chg_val;
      if (c == hole) drive(1'b0, c, {192{1'b1}}, s);
      for (int k = 0; k < 4; k++) begin
        r = {$urandom(), $urandom()};
        d[k*48 +: 48] = r[47:0] & fmask;
      end
      if (c == sp_cnt) d = sp;
      drive(1'b1, c, d, s);
    end
  endtask

  task automatic do_reset;
    rst = 1'b1;
    en_sync_in  = 1'b0;
    cnt_sync_in = '0;
    data_in     = '0;
    q.delete();
    @(posedge clk);
    #1;
    n_cmp++;
    if ({data_out, sat_out, en_sync_out, cnt_sync_out, cur_shift} !== '0) begin
      n_err++;
      $display("FAIL reset_path: got d=%h sat=%b en=%b cnt=%0d sh=%0d, want 0",
               data_out, sat_out, en_sync_out, cnt_sync_out, cur_shift);
    end
    n_cmp++;
    if ({frame_max, frame_max_valid, frame_sat} !== '0) begin
      n_err++;
      $display("FAIL reset_frame: got max=%h v=%b sat=%b, want 0",
               frame_max, frame_max_valid, frame_sat);
    end
    rst = 1'b0;
  endtask

  task automatic test_reset;
    mode = 1'b0;
    manual_shift = 6'd8;
    agc_headroom = 6'd0;
    do_reset();
  endtask

  task automatic test_manual_round;
    manual_shift = 6'd8;
    watch_cnt = 5;
    run_frame(0, 511, 8, 5, {144'd0, 48'h0000_0012_3480},
              48'hFFFF, -1, -1, 6'd0);
    idle(2, 8);
    n_cmp++;
    if ({snap_d[15:0], snap_sat[0], snap_s} !== {16'h1235, 1'b0, 6'd8}) begin
      n_err++;
      $display("FAIL round8: got %h sat=%b sh=%0d, want 1235 sat=0 sh=8",
               snap_d[15:0], snap_sat[0], snap_s);
    end
    n_cmp++;
    if (frame_sat !== 1'b0) begin
      n_err++;
      $display("FAIL round8_fsat: got %b, want 0", frame_sat);
    end
  endtask

  task automatic test_saturation;
    manual_shift = 6'd0;
    watch_cnt = 10;
    run_frame(0, 511, 0, 10, {96'd0, 48'h1_0000, 48'd0},
              48'hFFF, -1, -1, 6'd0);
    idle(2, 0);
    n_cmp++;
    if ({snap_d[31:16], snap_sat[1], frame_sat} !== {16'hFFFF, 2'b11}) begin
      n_err++;
      $display("FAIL sat_hi: got %h sat=%b fsat=%b, want FFFF 1 1",
               snap_d[31:16], snap_sat[1], frame_sat);
    end
    manual_shift = 6'd4;
    run_frame(0, 511, 4, 10, {48'd0, 48'hF_FFF8, 96'd0},
              48'hFFF, -1, -1, 6'd0);
    idle(2, 4);
    n_cmp++;
    if ({snap_d[47:32], snap_sat[2], frame_sat} !== {16'hFFFF, 2'b11}) begin
      n_err++;
      $display("FAIL sat_carry: got %h sat=%b fsat=%b, want FFFF 1 1",
               snap_d[47:32], snap_sat[2], frame_sat);
    end
  endtask

  task automatic test_peak;
    int v0;
    manual_shift = 6'd8;
    v0 = vcount;
    run_frame(0, 511, 8, 511, {48'h0000_0000_ABCD, 144'd0},
              48'hFF, 200, -1, 6'd0);
    idle(2, 8);
    n_cmp++;
    if (vcount - v0 !== 1) begin
      n_err++;
      $display("FAIL peak_pulses: got %0d, want 1", vcount - v0);
    end
    n_cmp++;
    if (last_fm !== 48'hABCD) begin
      n_err++;
      $display("FAIL peak_value: got %h, want abcd", last_fm);
    end
    n_cmp++;
    if (frame_sat !== 1'b0) begin
      n_err++;
      $display("FAIL peak_fsat: got %b, want 0", frame_sat);
    end
  endtask

  task automatic test_manual_shift;
    manual_shift = 6'd40;
    watch_cnt = 300;
    run_frame(0, 511, 32, -1, '0, 48'hFFFF_FFFF, -1, -1, 6'd0);
    n_cmp++;
    if (snap_s !== 6'd32) begin
      n_err++;
      $display("FAIL clamp40: got %0d, want 32", snap_s);
    end
    manual_shift = 6'd8;
    run_frame(0, 511, 8, -1, '0, 48'hFF_FFFF, -1, 100, 6'd4);
    n_cmp++;
    if (snap_s !== 6'd8) begin
      n_err++;
      $display("FAIL midframe_hold: got %0d, want 8", snap_s);
    end
    run_frame(0, 511, 4, -1, '0, 48'hF_FFFF, -1, -1, 6'd0);
    idle(2, 4);
    n_cmp++;
    if (snap_s !== 6'd4) begin
      n_err++;
      $display("FAIL next_frame_shift: got %0d, want 4", snap_s);
    end
  endtask

  task automatic agc_run(input logic [5:0] hr, input int want);
    do_reset();
    mode = 1'b1;
    agc_headroom = hr;
    watch_cnt = 77;
    run_frame(0, 511, 32, 77, {144'd0, 48'h0000_0100_0000},
              48'hFF, -1, -1, 6'd0);
    run_frame(0, 511, 32, -1, '0, 48'hFF, -1, -1, 6'd0);
    n_cmp++;
    if (snap_s !== 6'd32) begin
      n_err++;
      $display("FAIL agc_frame1 hr=%0d: got %0d, want 32", hr, snap_s);
    end
    run_frame(0, 511, want, -1, '0, 48'hFF, -1, -1, 6'd0);
    idle(2, want);
    n_cmp++;
    if (snap_s !== 6'(want)) begin
      n_err++;
      $display("FAIL agc_frame2 hr=%0d: got %0d, want %0d", hr, snap_s, want);
    end
  endtask

  task automatic test_agc;
    agc_run(6'd0, 9);
    agc_run(6'd2, 11);
  endtask

  task automatic test_reset_mid;
    int v0;
    mode = 1'b0;
    manual_shift = 6'd8;
    run_frame(0, 300, 8, 50, {144'd0, 48'hFFFF_0000_0000},
              48'hFF, -1, -1, 6'd0);
    do_reset();
    v0 = vcount;
    watch_cnt = 305;
    run_frame(301, 511, 32, -1, '0, 48'hFF, -1, -1, 6'd0);
    idle(2, 32);
    n_cmp++;
    if ({snap_s, 32'(vcount - v0)} !== {6'd32, 32'd0}) begin
      n_err++;
      $display("FAIL partial_frame: got sh=%0d pulses=%0d, want 32 0",
               snap_s, vcount - v0);
    end
    run_frame(0, 511, 8, 7, {96'd0, 48'h1234, 48'd0},
              48'hFF, -1, -1, 6'd0);
    idle(2, 8);
    n_cmp++;
    if ({last_fm, 32'(vcount - v0)} !== {48'h1234, 32'd1}) begin
      n_err++;
      $display("FAIL post_reset_peak: got %h pulses=%0d, want 1234 1",
               last_fm, vcount - v0);
    end
  endtask

  initial begin
    rst = 1'b1;
    en_sync_in = 1'b0;
    cnt_sync_in = '0;
    data_in = '0;
    mode = 1'b0;
    manual_shift = '0;
    agc_headroom = '0;
    #1;
    test_reset();
    test_manual_round();
    test_saturation();
    test_peak();
    test_manual_shift();
    test_agc();
    test_reset_mid();
    idle(3, 8);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
